// File: rtl/apb_uart_pkg.sv
// Shared APB UART types: CFG register layout, TX frame-sequencer states and helpers.
package apb_uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef struct packed {
    logic [28:0] reserved;
    logic        extra_stop_bits;
    logic        parity_type;
    logic        parity_en;
  } cfg_reg_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } uart_tx_state_e;

  // Even parity makes the total count of ones even; odd inverts it.
  function automatic logic frame_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud counter: counts 0..div_i and strobes bit_end_o on the final cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 start_i,
  output logic                 bit_end_o,
  output logic                 bit_end_next_o
);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else if (start_i || bit_end_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

  assign bit_end_o = (cnt == div_i);

  // Lookahead so the frame sequencer can register a strobe that lands on the last bit cycle.
  assign bit_end_next_o = bit_end_o ? (div_i == '0) : ((cnt + DIV_WIDTH'(1)) == div_i);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: pops TX FIFO bytes and serialises start/data/parity/stop bits.
// Parity generation is compiled in only when APB_UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import apb_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 clk_en_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic [31:0]          cfg_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  input  logic                 fifo_valid_i,
  output logic                 fifo_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  uart_tx_state_e       state;
  cfg_reg_t             cfg;
  logic [DATA_BITS-1:0] data_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 extra_q;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 handshake;
  logic                 last_data;
  logic                 parity_on;
  logic                 bit_end;
  logic                 bit_end_next;
  logic                 final_next;
  logic                 unused_cfg;

  assign cfg          = cfg_reg_t'(cfg_i);
  assign fifo_ready_o = (state == TX_IDLE) && clk_en_i && !arst_i;
  assign handshake    = fifo_ready_o && fifo_valid_i;
  assign idx_next     = idx + IDX_W'(1);
  assign last_data    = (idx == IDX_W'(DATA_BITS - 1));

`ifdef APB_UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  assign parity_on  = par_en_q;
  assign unused_cfg = ^cfg.reserved;
`else
  assign parity_on  = 1'b0;
  assign unused_cfg = ^{cfg.reserved, cfg.parity_en, cfg.parity_type};
`endif

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .div_i          (div_q),
    .start_i        (handshake),
    .bit_end_o      (bit_end),
    .bit_end_next_o (bit_end_next)
  );

  // True when the next cycle belongs to the frame's final stop bit.
  always_comb begin
    final_next = 1'b0;
    case (state)
      TX_DATA:   final_next = bit_end && last_data && !parity_on && !extra_q;
`ifdef APB_UART_TX_PARITY_EN
      TX_PARITY: final_next = bit_end && !extra_q;
`endif
      TX_STOP1:  final_next = extra_q ? bit_end : !bit_end;
      TX_STOP2:  final_next = !bit_end;
      default:   final_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= TX_IDLE;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      data_q  <= '0;
      div_q   <= '0;
      extra_q <= 1'b0;
      idx     <= '0;
`ifdef APB_UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_o <= final_next && bit_end_next;
      case (state)
        TX_IDLE: begin
          if (handshake) begin
            data_q  <= fifo_data_i;
            div_q   <= clk_div_i;
            extra_q <= cfg.extra_stop_bits;
            idx     <= '0;
`ifdef APB_UART_TX_PARITY_EN
            par_en_q  <= cfg.parity_en;
            par_bit_q <= frame_parity(fifo_data_i, cfg.parity_type);
`endif
            state   <= TX_START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state <= TX_DATA;
            tx_o  <= data_q[0];
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            idx <= idx_next;
            if (!last_data) begin
              tx_o <= data_q[idx_next];
`ifdef APB_UART_TX_PARITY_EN
            end else if (parity_on) begin
              state <= TX_PARITY;
              tx_o  <= par_bit_q;
`endif
            end else begin
              state <= TX_STOP1;
              tx_o  <= 1'b1;
            end
          end
        end
`ifdef APB_UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            state <= TX_STOP1;
            tx_o  <= 1'b1;
          end
        end
`endif
        TX_STOP1: begin
          if (bit_end) begin
            if (extra_q) begin
              state <= TX_STOP2;
            end else begin
              state  <= TX_IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        TX_STOP2: begin
          if (bit_end) begin
            state  <= TX_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= TX_IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: FIFO model, frame capture monitor and expected-frame scoreboard.
module tb_uart_tx_ctrl;
  import apb_uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b0;
  logic        clk_en_i = 1'b0;
  logic [31:0] clk_div_i = '0;
  logic [31:0] cfg_i = '0;
  logic [7:0]  fifo_data_i = '0;
  logic        fifo_valid_i = 1'b0;
  logic        fifo_ready_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    logic [7:0]  data;
    bit          par;
    bit          par_val;
    int unsigned stops;
    int unsigned div;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic       cap_tx[$];
  logic       cap_done[$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int bad_idle = 0;
  int idle_run = 0;
  int last_gap = 0;
  bit capturing = 1'b0;
  bit hs;

  uart_tx_ctrl #(
    .DATA_BITS(8),
    .DIV_WIDTH(32)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .clk_en_i     (clk_en_i),
    .clk_div_i    (clk_div_i),
    .cfg_i        (cfg_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_ready_o (fifo_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: the head byte leaves once the DUT accepted it on a rising edge.
  always begin
    @(posedge clk_i);
    hs = fifo_valid_i && fifo_ready_o;
    #1;
    if (hs && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    fifo_valid_i = (fifo_q.size() != 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  task automatic check_frame();
    exp_t        e;
    logic        bits[$];
    int unsigned per, exp_len, mism, dmism;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0d cycles, required no frame", cap_tx.size());
      return;
    end
    e = exp_q.pop_front();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
    if (e.par) bits.push_back(e.par_val);
    for (int unsigned i = 0; i < e.stops; i++) bits.push_back(1'b1);
    per     = e.div + 1;
    exp_len = bits.size() * per;
    checks++;
    if (cap_tx.size() !== exp_len) begin
      errors++;
      $display("FAIL frame_len byte=%02h: got %0d cycles, required %0d", e.data, cap_tx.size(), exp_len);
    end
    mism  = 0;
    dmism = 0;
    for (int unsigned i = 0; i < cap_tx.size(); i++) begin
      if (i < exp_len && cap_tx[i] !== bits[i / per]) mism++;
      if (cap_done[i] !== (i == exp_len - 1)) dmism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL frame_bits byte=%02h: got %0d wrong tx cycles, required 0", e.data, mism);
    end
    checks++;
    if (dmism != 0) begin
      errors++;
      $display("FAIL done_pulse byte=%02h: got %0d misplaced done cycles, required 0", e.data, dmism);
    end
  endtask

  always @(negedge clk_i) begin
    if (arst_i) begin
      capturing = 1'b0;
      idle_run  = 0;
    end else if (busy_o) begin
      if (!capturing) begin
        capturing = 1'b1;
        cap_tx.delete();
        cap_done.delete();
        last_gap = idle_run;
        idle_run = 0;
      end
      cap_tx.push_back(tx_o);
      cap_done.push_back(done_o);
    end else begin
      if (capturing) begin
        capturing = 1'b0;
        check_frame();
      end
      idle_run++;
      if (tx_o !== 1'b1) bad_idle++;
    end
  end

  task automatic set_cfg(input bit pe, input bit pt, input bit es);
    cfg_reg_t c;
    c = '0;
    c.parity_en       = pe;
    c.parity_type     = pt;
    c.extra_stop_bits = es;
    cfg_i = c;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit pe, input bit pt, input bit es,
                           input int unsigned div);
    exp_t e;
    int   ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    e.data = d;
`ifdef APB_UART_TX_PARITY_EN
    e.par = pe;
`else
    e.par = 1'b0;
`endif
    e.par_val = (ones % 2 == 1) ^ pt;
    e.stops   = es ? 2 : 1;
    e.div     = div;
    exp_q.push_back(e);
    fifo_q.push_back(d);
  endtask

  task automatic wait_all(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o || capturing || fifo_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout_%s: got %0d frames outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n;
    n = 0;
    while (!busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL busy_timeout_%s: got busy=%b, required 1", name, busy_o);
    end
  endtask

  task automatic test_reset();
    #2 arst_i = 1'b1;
    clk_en_i = 1'b1;
    #1;
    checks += 4;
    if (tx_o !== 1'b1)         begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_o); end
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    if (done_o !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, required 0", done_o); end
    if (fifo_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", fifo_ready_o); end
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    checks++;
    if (fifo_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, required 1", fifo_ready_o); end
  endtask

  task automatic test_basic_frame();
    @(negedge clk_i);
    clk_div_i = 32'd3;
    set_cfg(1'b0, 1'b0, 1'b0);
    push_byte(8'hA5, 1'b0, 1'b0, 1'b0, 3);
    wait_all("basic", 200);
  endtask

  task automatic test_parity();
    @(negedge clk_i);
    clk_div_i = 32'd0;
    set_cfg(1'b1, 1'b0, 1'b0);
    push_byte(8'h07, 1'b1, 1'b0, 1'b0, 0);
    wait_all("parity_even", 100);
    set_cfg(1'b1, 1'b1, 1'b0);
    push_byte(8'h07, 1'b1, 1'b1, 1'b0, 0);
    wait_all("parity_odd", 100);
  endtask

  task automatic test_back_to_back();
    int p0;
    @(negedge clk_i);
    clk_div_i = 32'd1;
    set_cfg(1'b0, 1'b0, 1'b1);
    p0 = pops;
    push_byte(8'h00, 1'b0, 1'b0, 1'b1, 1);
    push_byte(8'hFF, 1'b0, 1'b0, 1'b1, 1);
    wait_all("b2b", 300);
    checks += 2;
    if (pops - p0 !== 2) begin errors++; $display("FAIL b2b_pops: got %0d, required 2", pops - p0); end
    if (last_gap !== 1)  begin errors++; $display("FAIL b2b_gap: got %0d idle cycles, required 1", last_gap); end
  endtask

  task automatic test_clk_en_midframe();
    int p0, n;
    @(negedge clk_i);
    clk_div_i = 32'd2;
    set_cfg(1'b0, 1'b0, 1'b0);
    push_byte(8'h3C, 1'b0, 1'b0, 1'b0, 2);
    push_byte(8'h81, 1'b0, 1'b0, 1'b1, 5);
    wait_busy("clken", 50);
    repeat (5) @(negedge clk_i);
    clk_en_i  = 1'b0;
    clk_div_i = 32'd5;
    set_cfg(1'b0, 1'b0, 1'b1);
    p0 = pops;
    n = 0;
    while (exp_q.size() > 1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    repeat (10) @(negedge clk_i);
    checks += 3;
    if (n >= 200)       begin errors++; $display("FAIL clken_first_frame: got %0d pending, required 1", exp_q.size()); end
    if (pops !== p0)    begin errors++; $display("FAIL clken_pop: got %0d pops, required %0d", pops, p0); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL clken_busy: got %b, required 0", busy_o); end
    clk_en_i = 1'b1;
    wait_all("clken", 400);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk_i);
    clk_div_i = 32'd2;
    set_cfg(1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'h99);
    wait_busy("rst_mid", 50);
    repeat (6) @(negedge clk_i);
    #2 arst_i = 1'b1;
    #1;
    checks += 3;
    if (tx_o !== 1'b1)   begin errors++; $display("FAIL midrst_tx: got %b, required 1", tx_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b, required 0", done_o); end
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    push_byte(8'h55, 1'b0, 1'b0, 1'b0, 2);
    wait_all("rst_mid", 200);
  endtask

  task automatic test_parity_cfg_ignored();
    @(negedge clk_i);
    clk_div_i = 32'd0;
    set_cfg(1'b1, 1'b0, 1'b0);
    push_byte(8'h07, 1'b1, 1'b0, 1'b0, 0);
    wait_all("macro", 100);
    checks++;
    if (bad_idle !== 0) begin errors++; $display("FAIL idle_line: got %0d low idle cycles, required 0", bad_idle); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_clk_en_midframe();
    test_reset_midframe();
    test_parity_cfg_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
